// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and elaboration helpers for the Wishbone
// round-robin arbiter.
//   arb_state_e - arbiter FSM states
//   clog2()     - ceiling log2 used for pointer and timer widths
//   max_out()   - highest outstanding-request count for a burst depth
//   timer_w()   - watchdog timer width, at least 1 bit
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ABORT   = 2'd2
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // MAXOUT = 2^LGMAXBURST - 1
    function automatic int max_out(input int lg);
        return (1 << lg) - 1;
    endfunction

    // Timer must hold the value TIMEOUT; TIMEOUT=0 still needs a 1-bit reg.
    function automatic int timer_w(input int timeout);
        int w;
        w = clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// wb_rr_arbiter_rr_pick: combinational round-robin selector.
//   req_i   - request vector, one bit per master
//   ptr_i   - index where the search starts (wraps modulo NM)
//   pick_o  - one-hot winner, zero when no request
//   valid_o - at least one request present
module wb_rr_arbiter_rr_pick #(
    parameter int NM = 4,
    parameter int PW = 2
) (
    input  logic [NM-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NM-1:0] pick_o,
    output logic          valid_o
);

    logic found;

    // Walk offsets 0..NM-1 from the pointer; the first requester hit wins.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            for (int m = 0; m < NM; m++) begin
                if (!found && req_i[m] && (m == (int'(ptr_i) + i) % NM)) begin
                    pick_o[m] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: shares one pipelined Wishbone slave port between NM masters.
// Round-robin grant held for the whole CYC of the winner, with an
// outstanding-request counter and an ack-timeout watchdog.
//   i_clk, i_reset        - clock, asynchronous active-high reset
//   i_mcyc/i_mstb/i_mwe   - per-master CYC/STB/WE
//   i_maddr/i_mdata/i_msel- per-master address/write data/selects (packed)
//   o_mstall/o_mack/o_merr- per-master STALL/ACK/ERR
//   o_mdata               - read data broadcast to all masters
//   o_s*                  - slave-side request signals
//   i_sstall/i_sack/i_serr/i_sdata - slave responses
//   o_grant               - one-hot current grant, zero when idle
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM         = 4,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LGMAXBURST = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NM-1:0]        i_mcyc,
    input  logic [NM-1:0]        i_mstb,
    input  logic [NM-1:0]        i_mwe,
    input  logic [NM*AW-1:0]     i_maddr,
    input  logic [NM*DW-1:0]     i_mdata,
    input  logic [NM*DW/8-1:0]   i_msel,
    output logic [NM-1:0]        o_mstall,
    output logic [NM-1:0]        o_mack,
    output logic [NM-1:0]        o_merr,
    output logic [DW-1:0]        o_mdata,
    output logic                 o_scyc,
    output logic                 o_sstb,
    output logic                 o_swe,
    output logic [AW-1:0]        o_saddr,
    output logic [DW-1:0]        o_sdata,
    output logic [DW/8-1:0]      o_ssel,
    input  logic                 i_sstall,
    input  logic                 i_sack,
    input  logic                 i_serr,
    input  logic [DW-1:0]        i_sdata,
    output logic [NM-1:0]        o_grant
);

    localparam int SW     = DW / 8;
    localparam int GW     = (clog2(NM) < 1) ? 1 : clog2(NM);
    localparam int TW     = timer_w(TIMEOUT);
    localparam int MAXOUT = max_out(LGMAXBURST);
    localparam logic [LGMAXBURST-1:0] OUT_FULL = LGMAXBURST'(MAXOUT);
    localparam logic [TW-1:0]         TMO      = TW'(TIMEOUT);

    arb_state_e            state_q, state_d;
    logic [NM-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [LGMAXBURST-1:0] outs_q, outs_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [NM-1:0] pick;
    logic          pick_vld;
    logic [GW-1:0] g_idx;
    logic [GW-1:0] next_rr;
    logic          cyc_g, stb_g;
    logic          full, timeout, ack_any, accept, dec;

    wb_rr_arbiter_rr_pick #(.NM(NM), .PW(GW)) u_pick (
        .req_i   (i_mcyc & i_mstb),
        .ptr_i   (rr_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    assign o_grant = grant_q;
    assign cyc_g   = |(i_mcyc & grant_q);
    assign stb_g   = |(i_mstb & grant_q);
    assign full    = (outs_q == OUT_FULL);
    assign ack_any = i_sack | i_serr;
    assign timeout = (TIMEOUT != 0) && (state_q == GRANTED) && (timer_q == TMO);
    assign accept  = o_sstb & ~i_sstall;
    // A stray ack with nothing outstanding is forwarded but not counted.
    assign dec     = ack_any && (outs_q != '0);
    assign next_rr = (int'(g_idx) == NM - 1) ? '0 : g_idx + GW'(1);

    // Request mux from the granted master; grant is one-hot or zero.
    always_comb begin
        g_idx   = '0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        for (int m = 0; m < NM; m++) begin
            if (grant_q[m]) begin
                g_idx   = GW'(m);
                o_swe   = i_mwe[m];
                o_saddr = i_maddr[m*AW +: AW];
                o_sdata = i_mdata[m*DW +: DW];
                o_ssel  = i_msel[m*SW +: SW];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = GRANTED;
            GRANTED: begin
                if (!cyc_g)       state_d = IDLE;
                else if (timeout) state_d = ABORT;
            end
            ABORT:   if (!cyc_g) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_scyc   = 1'b0;
        o_sstb   = 1'b0;
        o_mstall = '1;
        o_mack   = '0;
        o_merr   = '0;
        o_mdata  = i_sdata;
        if (state_q == GRANTED) begin
            // Timeout drops CYC in the same cycle the error is reported.
            o_scyc   = cyc_g & ~timeout;
            o_sstb   = stb_g & ~full & ~timeout;
            o_mstall = ~grant_q | {NM{i_sstall | full | timeout}};
            o_mack   = grant_q & {NM{i_sack}};
            o_merr   = grant_q & {NM{i_serr | timeout}};
        end
    end

    // Grant, pointer, outstanding counter and watchdog timer
    always_comb begin
        grant_d = grant_q;
        rr_d    = rr_q;
        outs_d  = outs_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                outs_d  = '0;
                timer_d = '0;
                if (pick_vld) grant_d = pick;
            end
            GRANTED: begin
                if (!cyc_g) begin
                    grant_d = '0;
                    rr_d    = next_rr;
                    outs_d  = '0;
                    timer_d = '0;
                end else begin
                    if (accept && !dec)      outs_d = outs_q + LGMAXBURST'(1);
                    else if (!accept && dec) outs_d = outs_q - LGMAXBURST'(1);
                    if (TIMEOUT == 0 || ack_any || outs_q == '0) timer_d = '0;
                    else if (!timeout)                            timer_d = timer_q + TW'(1);
                end
            end
            ABORT: begin
                if (!cyc_g) begin
                    grant_d = '0;
                    rr_d    = next_rr;
                    outs_d  = '0;
                    timer_d = '0;
                end
            end
            default: begin
                grant_d = '0;
                outs_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            grant_q <= '0;
            rr_q    <= '0;
            outs_q  <= '0;
            timer_q <= '0;
        end else begin
            grant_q <= grant_d;
            rr_q    <= rr_d;
            outs_q  <= outs_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter
// (NM=4, LGMAXBURST=2, TIMEOUT=8). Inputs change on the falling edge;
// outputs are sampled 1 ns later.
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LGMAXBURST = 2;
    localparam int TIMEOUT = 8;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic [NM-1:0]       i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0]    i_maddr;
    logic [NM*DW-1:0]    i_mdata;
    logic [NM*DW/8-1:0]  i_msel;
    logic [NM-1:0]       o_mstall, o_mack, o_merr, o_grant;
    logic [DW-1:0]       o_mdata, o_sdata, i_sdata;
    logic                o_scyc, o_sstb, o_swe;
    logic [AW-1:0]       o_saddr;
    logic [DW/8-1:0]     o_ssel;
    logic                i_sstall, i_sack, i_serr;

    int checks = 0;
    int failures = 0;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .LGMAXBURST(LGMAXBURST), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mstall(o_mstall), .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
        .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
        .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
        .i_sstall(i_sstall), .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata),
        .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    task automatic test_reset;
        i_reset = 1'b1;
        i_mcyc = '0; i_mstb = '0; i_mwe = 4'b0100;
        i_sstall = 1'b0; i_sack = 1'b0; i_serr = 1'b0; i_sdata = '0;
        for (int m = 0; m < NM; m++) begin
            i_maddr[m*AW +: AW] = 32'h1000_0000 + m;
            i_mdata[m*DW +: DW] = 32'hD000_0000 + m;
            i_msel[m*4 +: 4]    = 4'(m + 1);
        end
        #1;
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", o_grant); end
        checks++; if (o_scyc !== 1'b0) begin failures++; $display("FAIL rst_scyc got=%b exp=0", o_scyc); end
        checks++; if (o_sstb !== 1'b0) begin failures++; $display("FAIL rst_sstb got=%b exp=0", o_sstb); end
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL rst_mstall got=%b exp=1111", o_mstall); end
        checks++; if (o_mack !== 4'b0000) begin failures++; $display("FAIL rst_mack got=%b exp=0000", o_mack); end
        checks++; if (o_merr !== 4'b0000) begin failures++; $display("FAIL rst_merr got=%b exp=0000", o_merr); end
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Masters 0 and 2 request together from rr=0; one idle bubble between tenures.
    task automatic test_arb_latency;
        @(negedge i_clk); #1;
        i_sstall = 1'b1; i_mcyc = 4'b0101; i_mstb = 4'b0101;
        #1;
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL arb_lat0 got=%b exp=0000", o_grant); end
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL arb_grant0 got=%b exp=0001", o_grant); end
        checks++; if (o_scyc !== 1'b1) begin failures++; $display("FAIL arb_scyc got=%b exp=1", o_scyc); end
        checks++; if (o_sstb !== 1'b1) begin failures++; $display("FAIL arb_sstb got=%b exp=1", o_sstb); end
        checks++; if (o_saddr !== 32'h1000_0000) begin failures++; $display("FAIL arb_saddr0 got=%h exp=10000000", o_saddr); end
        checks++; if (o_swe !== 1'b0) begin failures++; $display("FAIL arb_swe0 got=%b exp=0", o_swe); end
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL arb_mstall got=%b exp=1111", o_mstall); end
        i_mcyc = 4'b0100; i_mstb = 4'b0100;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL arb_bubble got=%b exp=0000", o_grant); end
        checks++; if (o_scyc !== 1'b0) begin failures++; $display("FAIL arb_bubble_scyc got=%b exp=0", o_scyc); end
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0100) begin failures++; $display("FAIL arb_grant2 got=%b exp=0100", o_grant); end
        checks++; if (o_saddr !== 32'h1000_0002) begin failures++; $display("FAIL arb_saddr2 got=%h exp=10000002", o_saddr); end
        checks++; if (o_swe !== 1'b1) begin failures++; $display("FAIL arb_swe2 got=%b exp=1", o_swe); end
        checks++; if (o_ssel !== 4'h3) begin failures++; $display("FAIL arb_ssel2 got=%h exp=3", o_ssel); end
        checks++; if (o_sdata !== 32'hD000_0002) begin failures++; $display("FAIL arb_sdata2 got=%h exp=d0000002", o_sdata); end
        i_mcyc = '0; i_mstb = '0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL arb_release got=%b exp=0000", o_grant); end
    endtask

    // Master 1: two stall cycles, three accepted reads, three acks with data.
    task automatic test_pipelined_reads;
        @(negedge i_clk); #1;
        i_mcyc = 4'b0010; i_mstb = 4'b0010; i_sstall = 1'b1;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0010) begin failures++; $display("FAIL pipe_grant got=%b exp=0010", o_grant); end
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL pipe_stall1 got=%b exp=1111", o_mstall); end
        @(negedge i_clk); #1;
        checks++; if (o_mack !== 4'b0000) begin failures++; $display("FAIL pipe_noack got=%b exp=0000", o_mack); end
        i_sstall = 1'b0;
        #1;
        checks++; if (o_mstall !== 4'b1101) begin failures++; $display("FAIL pipe_unstall got=%b exp=1101", o_mstall); end
        @(negedge i_clk); #1;
        checks++; if (dut.outs_q !== 2'd1) begin failures++; $display("FAIL pipe_outs1 got=%0d exp=1", dut.outs_q); end
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL pipe_full_stall got=%b exp=1111", o_mstall); end
        i_mstb = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin @(negedge i_clk); #1; end
            i_sack = 1'b1; i_sdata = 32'hA5A5_0000 + k;
            #1;
            checks++; if (o_mack !== 4'b0010) begin failures++; $display("FAIL pipe_ack%0d got=%b exp=0010", k, o_mack); end
            checks++; if (o_mdata !== 32'hA5A5_0000 + k) begin failures++; $display("FAIL pipe_data%0d got=%h exp=%h", k, o_mdata, 32'hA5A5_0000 + k); end
        end
        @(negedge i_clk); #1;
        i_sack = 1'b0;
        #1;
        checks++; if (dut.outs_q !== 2'd0) begin failures++; $display("FAIL pipe_outs0 got=%0d exp=0", dut.outs_q); end
        checks++; if (o_mack !== 4'b0000) begin failures++; $display("FAIL pipe_ackend got=%b exp=0000", o_mack); end
        i_mcyc = '0;
        @(negedge i_clk);
    endtask

    // Master 3 (rr=2): simultaneous accept+ack, then fill to MAXOUT=3.
    task automatic test_same_cycle_full;
        @(negedge i_clk); #1;
        i_mcyc = 4'b1000; i_mstb = 4'b1000; i_sstall = 1'b0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b1000) begin failures++; $display("FAIL sc_grant got=%b exp=1000", o_grant); end
        @(negedge i_clk); #1;
        i_sack = 1'b1;
        #1;
        checks++; if (o_mack !== 4'b1000) begin failures++; $display("FAIL sc_ack got=%b exp=1000", o_mack); end
        @(negedge i_clk); #1;
        i_sack = 1'b0;
        checks++; if (dut.outs_q !== 2'd1) begin failures++; $display("FAIL sc_outs_hold got=%0d exp=1", dut.outs_q); end
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        checks++; if (dut.outs_q !== 2'd3) begin failures++; $display("FAIL sc_outs_full got=%0d exp=3", dut.outs_q); end
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL sc_full_stall got=%b exp=1111", o_mstall); end
        checks++; if (o_sstb !== 1'b0) begin failures++; $display("FAIL sc_full_sstb got=%b exp=0", o_sstb); end
        i_mcyc = '0; i_mstb = '0;
        @(negedge i_clk);
    endtask

    // All masters request from rr=0; each tenure ends with a CYC drop.
    task automatic test_round_robin;
        logic [NM-1:0] e;
        @(negedge i_clk); #1;
        i_mcyc = 4'b1111; i_mstb = 4'b1111; i_sstall = 1'b1; i_sack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            e = 4'b0001 << (t % 4);
            @(negedge i_clk); #1;
            checks++; if (o_grant !== e) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", t, o_grant, e); end
            checks++; if (o_mack !== e) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", t, o_mack, e); end
            checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL rr_stall%0d got=%b exp=1111", t, o_mstall); end
            i_mcyc = i_mcyc & ~e; i_mstb = i_mstb & ~e;
            @(negedge i_clk); #1;
            checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL rr_idle%0d got=%b exp=0000", t, o_grant); end
            if (t < 4) begin i_mcyc = i_mcyc | e; i_mstb = i_mstb | e; end
            else begin i_mcyc = '0; i_mstb = '0; end
        end
        i_sack = 1'b0;
    endtask

    // One accepted request, no ack: error 9 cycles after acceptance, then ABORT.
    task automatic test_watchdog;
        @(negedge i_clk); #1;
        i_mcyc = 4'b0001; i_mstb = 4'b0001; i_sstall = 1'b0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL wd_grant got=%b exp=0001", o_grant); end
        checks++; if (o_sstb !== 1'b1) begin failures++; $display("FAIL wd_accept got=%b exp=1", o_sstb); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk); #1;
            i_mstb = '0;
            #1;
            checks++; if (o_merr !== 4'b0000) begin failures++; $display("FAIL wd_early%0d got=%b exp=0000", k, o_merr); end
            checks++; if (o_scyc !== 1'b1) begin failures++; $display("FAIL wd_scyc%0d got=%b exp=1", k, o_scyc); end
        end
        @(negedge i_clk); #1;
        checks++; if (o_merr !== 4'b0001) begin failures++; $display("FAIL wd_err got=%b exp=0001", o_merr); end
        checks++; if (o_scyc !== 1'b0) begin failures++; $display("FAIL wd_scyc_drop got=%b exp=0", o_scyc); end
        @(negedge i_clk); #1;
        i_sack = 1'b1;
        #1;
        checks++; if (o_merr !== 4'b0000) begin failures++; $display("FAIL ab_err got=%b exp=0000", o_merr); end
        checks++; if (o_scyc !== 1'b0) begin failures++; $display("FAIL ab_scyc got=%b exp=0", o_scyc); end
        checks++; if (o_mack !== 4'b0000) begin failures++; $display("FAIL ab_ack got=%b exp=0000", o_mack); end
        checks++; if (o_mstall !== 4'b1111) begin failures++; $display("FAIL ab_stall got=%b exp=1111", o_mstall); end
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL ab_grant got=%b exp=0001", o_grant); end
        i_sack = 1'b0; i_mcyc = '0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL ab_release got=%b exp=0000", o_grant); end
    endtask

    // Reset with two requests outstanding; afterwards rr pointer is 0 again.
    task automatic test_reset_mid;
        @(negedge i_clk); #1;
        i_mcyc = 4'b0100; i_mstb = 4'b0100; i_sstall = 1'b0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0100) begin failures++; $display("FAIL rm_grant got=%b exp=0100", o_grant); end
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        i_mstb = '0; i_sack = 1'b1;
        #1;
        checks++; if (o_mack !== 4'b0100) begin failures++; $display("FAIL rm_ack got=%b exp=0100", o_mack); end
        checks++; if (dut.outs_q !== 2'd2) begin failures++; $display("FAIL rm_outs got=%0d exp=2", dut.outs_q); end
        i_reset = 1'b1;
        #1;
        checks++; if (o_scyc !== 1'b0) begin failures++; $display("FAIL rm_scyc got=%b exp=0", o_scyc); end
        checks++; if (o_grant !== 4'b0000) begin failures++; $display("FAIL rm_grant_clr got=%b exp=0000", o_grant); end
        checks++; if (o_mack !== 4'b0000) begin failures++; $display("FAIL rm_ack_clr got=%b exp=0000", o_mack); end
        checks++; if (dut.outs_q !== 2'd0) begin failures++; $display("FAIL rm_outs_clr got=%0d exp=0", dut.outs_q); end
        i_sack = 1'b0; i_mcyc = 4'b1001; i_mstb = 4'b1001;
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk); #1;
        checks++; if (o_grant !== 4'b0001) begin failures++; $display("FAIL rm_regrant got=%b exp=0001", o_grant); end
        i_mcyc = '0; i_mstb = '0;
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_arb_latency();
        test_pipelined_reads();
        test_same_cycle_full();
        test_round_robin();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
